fetch_control_sequencer: RTL
============================

Name: fetch_control_sequencer

Overview:
- Owns the program counter and the instruction register for the 24-bit CPU.
- Fetches each instruction over a req/ready handshake, decodes the 4-bit opcode, and drives the datapath control strobes for one or two cycles.
- Takes the datapath's branch-resolved next PC back as an input.
- It is the producer side of the datapath's PC/Instruction/control interface: the datapath consumes what this block sequences.

Parameters:
RESET_PC, 24'h000000, PC value loaded on reset.
PC_STEP, 24'd3, sequential PC increment (3 bytes per 24-bit instruction).

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
imem_req  output  1  instruction fetch request
imem_addr  output  24  fetch address (equals PC)
imem_ready  input  1  fetch accepted; imem_rdata valid this cycle
imem_rdata  input  24  fetched instruction word
pc_beq_in  input  24  branch-resolved next PC from datapath
PC  output  24  current program counter
Instruction  output  24  instruction register
RegDst, ALUsrc, MemToReg, Regwrite, MemRead, MemWrite, Branch  output  1 each  datapath controls
ALUop  output  2  ALU operation class
halted  output  1  sticky, set by HALT
illegal_op  output  1  sticky, set by undefined opcode
retired  output  16  retired-instruction counter

Behaviour:
- Reset (async, immediate):
  - PC=RESET_PC, Instruction=0, all controls=0, halted=0, illegal_op=0, retired=0, state=FETCH.
  - imem_req is gated low while reset is high.
  - Reset mid-fetch or mid-execute aborts the instruction with no strobe leakage.
- States:
  - FETCH: imem_req=1, imem_addr=PC. On an edge with imem_req&&imem_ready, Instruction<=imem_rdata and go to EXEC. imem_ready outside FETCH is ignored.
  - EXEC: decoded controls asserted for exactly one cycle. LW goes to WB. All other opcodes update PC, increment retired, and return to FETCH, except HALT.
  - WB (LW only): MemRead=1, MemToReg=1, Regwrite=1, ALUsrc=1, ALUop=00 for one cycle. Then PC<=PC+PC_STEP, retired++, go to FETCH.
  - HALT: all controls 0, imem_req=0, halted=1. Stays until reset; PC and retired frozen.
- Decode of Instruction[23:20], asserted in EXEC:
  - 0000 R-type: RegDst=1, Regwrite=1, ALUop=10.
  - 0001 ADDI: ALUsrc=1, Regwrite=1, ALUop=00.
  - 0010 LW: ALUsrc=1, MemRead=1, MemToReg=1, ALUop=00. Regwrite=0 in EXEC and 1 only in WB, so the register file writes only after memory data is valid.
  - 0011 SW: ALUsrc=1, MemWrite=1, ALUop=00.
  - 0100 BEQ: Branch=1, ALUop=01.
  - 1111 HALT: no controls. Enters HALT, no PC update, retired not incremented.
  - Others: all controls 0 (NOP), illegal_op<=1 (sticky), PC advances and retired increments.
- Controls are 0 in FETCH and HALT. Controls are registered-state decoded only, with no dependency on imem_rdata.
- PC update at end of EXEC:
  - BEQ: PC<=pc_beq_in.
  - Otherwise: PC<=PC+PC_STEP, modulo 2^24 (24'hFFFFFD+3 wraps to 24'h000000).
- Latency with imem_ready tied high: 2 cycles per instruction; LW 3 cycles. Each wait cycle on imem_ready adds one cycle in FETCH.
- retired wraps 16'hFFFF to 0.

Test Plan:
- Reset release, imem_ready=1, imem_rdata=24'h012345 (R-type) -> cycle 1: imem_req=1, addr=0. Cycle 2: EXEC, RegDst=Regwrite=1, ALUop=10. Cycle 3: PC=3, retired=1.
- LW (24'h2...) with imem_ready=1 -> EXEC: MemRead=1, Regwrite=0. WB: Regwrite=1, MemToReg=1. Then PC=+3 after 3 cycles total.
- BEQ with pc_beq_in=24'h000030 -> Branch=1, ALUop=01 for one cycle; next fetch addr=24'h000030.
- imem_ready held low 4 cycles in FETCH -> imem_req stays 1, controls 0, PC unchanged. Data latched on the 5th cycle.
- Opcode 0111 then HALT -> illegal_op=1, PC+3, retired+1. Then halted=1, imem_req=0, PC frozen for 20 cycles.
- Reset asserted during LW WB -> Regwrite falls immediately, PC=RESET_PC, retired=0.

Source files
------------

// File: rtl/fetch_control_sequencer.sv
// fetch_control_sequencer
//   Program counter and instruction register owner for the 24-bit CPU.
//   Fetches one instruction word per req/ready handshake, decodes the
//   4-bit opcode in Instruction[23:20], and drives the datapath control
//   strobes for one cycle (two for LW: EXEC then WB).
//
// Ports
//   clock        rising-edge system clock
//   reset        asynchronous, active-high reset
//   imem_req     instruction fetch request (low during reset and HALT)
//   imem_addr    fetch address, always equal to PC
//   imem_ready   fetch accepted; imem_rdata valid this cycle
//   imem_rdata   fetched instruction word
//   pc_beq_in    branch-resolved next PC from the datapath
//   PC           current program counter
//   Instruction  instruction register
//   RegDst, ALUsrc, MemToReg, Regwrite, MemRead, MemWrite, Branch
//                datapath control strobes
//   ALUop        ALU operation class
//   halted       sticky, set by HALT
//   illegal_op   sticky, set by an undefined opcode
//   retired      retired-instruction counter (wraps)
module fetch_control_sequencer #(
  parameter logic [23:0] RESET_PC = 24'h000000,
  parameter logic [23:0] PC_STEP  = 24'd3
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [23:0] imem_addr,
  input  logic        imem_ready,
  input  logic [23:0] imem_rdata,
  input  logic [23:0] pc_beq_in,
  output logic [23:0] PC,
  output logic [23:0] Instruction,
  output logic        RegDst,
  output logic        ALUsrc,
  output logic        MemToReg,
  output logic        Regwrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        Branch,
  output logic [1:0]  ALUop,
  output logic        halted,
  output logic        illegal_op,
  output logic [15:0] retired
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_WB    = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  typedef enum logic [3:0] {
    OP_RTYPE = 4'h0,
    OP_ADDI  = 4'h1,
    OP_LW    = 4'h2,
    OP_SW    = 4'h3,
    OP_BEQ   = 4'h4,
    OP_HALT  = 4'hF
  } opcode_e;

  state_e      r_state;
  state_e      w_next;
  logic [23:0] r_pc;
  logic [23:0] r_instr;
  logic        r_halted;
  logic        r_illegal;
  logic [15:0] r_retired;

  logic [3:0]  w_op;
  logic        w_reg_dst;
  logic        w_alu_src;
  logic        w_mem_to_reg;
  logic        w_reg_write;
  logic        w_mem_read;
  logic        w_mem_write;
  logic        w_branch;
  logic [1:0]  w_alu_op;
  logic        w_is_illegal;
  logic        w_retire;
  logic        w_take_branch;

  assign w_op = r_instr[23:20];

  // Controls depend only on registered state and the instruction register,
  // never on imem_rdata, so they are glitch-free with respect to the fetch bus.
  always_comb begin
    w_next        = r_state;
    w_reg_dst     = 1'b0;
    w_alu_src     = 1'b0;
    w_mem_to_reg  = 1'b0;
    w_reg_write   = 1'b0;
    w_mem_read    = 1'b0;
    w_mem_write   = 1'b0;
    w_branch      = 1'b0;
    w_alu_op      = 2'b00;
    w_is_illegal  = 1'b0;
    w_retire      = 1'b0;
    w_take_branch = 1'b0;

    case (r_state)
      S_FETCH: begin
        if (imem_ready) w_next = S_EXEC;
      end

      S_EXEC: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
        case (w_op)
          OP_RTYPE: begin
            w_reg_dst   = 1'b1;
            w_reg_write = 1'b1;
            w_alu_op    = 2'b10;
          end
          OP_ADDI: begin
            w_alu_src   = 1'b1;
            w_reg_write = 1'b1;
          end
          OP_LW: begin
            // Register write deferred to WB, once memory data is valid.
            w_alu_src    = 1'b1;
            w_mem_read   = 1'b1;
            w_mem_to_reg = 1'b1;
            w_next       = S_WB;
            w_retire     = 1'b0;
          end
          OP_SW: begin
            w_alu_src   = 1'b1;
            w_mem_write = 1'b1;
          end
          OP_BEQ: begin
            w_branch      = 1'b1;
            w_alu_op      = 2'b01;
            w_take_branch = 1'b1;
          end
          OP_HALT: begin
            w_next   = S_HALT;
            w_retire = 1'b0;
          end
          default: begin
            w_is_illegal = 1'b1;
          end
        endcase
      end

      S_WB: begin
        w_mem_read   = 1'b1;
        w_mem_to_reg = 1'b1;
        w_reg_write  = 1'b1;
        w_alu_src    = 1'b1;
        w_next       = S_FETCH;
        w_retire     = 1'b1;
      end

      S_HALT: begin
        w_next = S_HALT;
      end

      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_pc      <= RESET_PC;
      r_instr   <= '0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH && imem_ready) r_instr <= imem_rdata;
      if (w_retire) begin
        r_pc      <= w_take_branch ? pc_beq_in : r_pc + PC_STEP;
        r_retired <= r_retired + 16'd1;
      end
      if (w_is_illegal) r_illegal <= 1'b1;
      if (r_state == S_EXEC && w_next == S_HALT) r_halted <= 1'b1;
    end
  end

  assign imem_req    = (r_state == S_FETCH) && !reset;
  assign imem_addr   = r_pc;
  assign PC          = r_pc;
  assign Instruction = r_instr;
  assign RegDst      = w_reg_dst;
  assign ALUsrc      = w_alu_src;
  assign MemToReg    = w_mem_to_reg;
  assign Regwrite    = w_reg_write;
  assign MemRead     = w_mem_read;
  assign MemWrite    = w_mem_write;
  assign Branch      = w_branch;
  assign ALUop       = w_alu_op;
  assign halted      = r_halted;
  assign illegal_op  = r_illegal;
  assign retired     = r_retired;

endmodule
